// File: rtl/wasm_leb_pkg.sv
// wasm_leb128_decoder shared types and constants.
// Strict range checking is enabled with WASM_LEB128_STRICT_EN.
package wasm_leb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } leb_state_t;

  typedef enum logic [1:0] {
    LEB_OK       = 2'b00,
    LEB_OVERLONG = 2'b01,
    LEB_OVERFLOW = 2'b10
  } leb_err_t;

  localparam logic [3:0] LEB_MAX32 = 4'd5;
  localparam logic [3:0] LEB_MAX64 = 4'd10;

  function automatic logic [6:0] leb_shamt(
    input logic [3:0] cnt
  );
    return {3'b000, cnt} * 7'd7;
  endfunction

endpackage

// File: rtl/wasm_leb128_finalize.sv
// LEB128 finalise: sign/zero extension, truncation, range check.
// Range check only exists when WASM_LEB128_STRICT_EN is defined.
module wasm_leb128_finalize
  import wasm_leb_pkg::*;
(
  input  logic [63:0] acc,
  input  logic [3:0]  cnt,
  input  logic [6:0]  last,
  input  logic        is_signed,
  input  logic        is_64,
  output logic [63:0] value,
  output leb_err_t    err
);

  logic [6:0]  sh;
  logic [63:0] fill;
  logic [63:0] ext;

  // extend the accumulated payload and apply the width rules
  always_comb begin
    sh   = leb_shamt(cnt);
    fill = '0;
    if (is_signed && last[6] && (sh < 7'd64)) begin
      fill = ~((64'd1 << sh[5:0]) - 64'd1);
    end
    ext = acc | fill;
    if (is_64) begin
      value = ext;
    end else if (is_signed) begin
      value = {{32{ext[31]}}, ext[31:0]};
    end else begin
      value = {32'b0, ext[31:0]};
    end
    err = LEB_OK;
`ifdef WASM_LEB128_STRICT_EN
    if (cnt == (is_64 ? LEB_MAX64 : LEB_MAX32)) begin
      unique case (1'b1)
        (!is_64 && !is_signed): begin
          if (last[6:4] != 3'b000) err = LEB_OVERFLOW;
        end
        (!is_64 && is_signed): begin
          if ((last[6:3] != 4'h0) && (last[6:3] != 4'hf))
            err = LEB_OVERFLOW;
        end
        (is_64 && !is_signed): begin
          if (last[6:1] != 6'd0) err = LEB_OVERFLOW;
        end
        default: begin
          if ((last != 7'h00) && (last != 7'h7f))
            err = LEB_OVERFLOW;
        end
      endcase
    end
`endif
  end

endmodule

// File: rtl/wasm_leb128_decoder.sv
// WebAssembly LEB128 immediate decoder (u32/s32/u64/s64).
// Define WASM_LEB128_STRICT_EN for value-range overflow errors.
module wasm_leb128_decoder
  import wasm_leb_pkg::*;
#(
  parameter int MAX_BYTES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_signed,
  input  logic        is_64,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_value,
  output logic [3:0]  out_len,
  output logic [1:0]  out_error
);

  leb_state_t  state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sgn_q, sgn_d;
  logic        w64_q, w64_d;
  logic [63:0] val_q, val_d;
  logic [3:0]  len_q, len_d;
  leb_err_t    err_q, err_d;

  logic [63:0] acc_nx;
  logic [3:0]  cnt_nx;
  logic [3:0]  limit;
  logic [63:0] fin_val;
  leb_err_t    fin_err;

  assign acc_nx = acc_q
    | ({57'd0, in_data[6:0]} << leb_shamt(cnt_q));
  assign cnt_nx = cnt_q + 4'd1;
  assign limit  = w64_q ? 4'(MAX_BYTES) : LEB_MAX32;

  wasm_leb128_finalize u_fin (
    .acc       (acc_nx),
    .cnt       (cnt_nx),
    .last      (in_data[6:0]),
    .is_signed (sgn_q),
    .is_64     (w64_q),
    .value     (fin_val),
    .err       (fin_err)
  );

  // next-state, accumulation and result capture
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    w64_d   = w64_q;
    val_d   = val_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sgn_d   = is_signed;
          w64_d   = is_64;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          acc_d = acc_nx;
          cnt_d = cnt_nx;
          if (!in_data[7]) begin
            state_d = DONE;
            len_d   = cnt_nx;
            err_d   = fin_err;
            val_d   = (fin_err == LEB_OK) ? fin_val : '0;
          end else if (cnt_nx == limit) begin
            state_d = DONE;
            len_d   = limit;
            err_d   = LEB_OVERLONG;
            val_d   = '0;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      w64_q   <= 1'b0;
      val_q   <= '0;
      len_q   <= '0;
      err_q   <= LEB_OK;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      w64_q   <= w64_d;
      val_q   <= val_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign out_value = val_q;
  assign out_len   = len_q;
  assign out_error = err_q;

endmodule

// File: doc/wasm_leb128_decoder.md
Name: wasm_leb128_decoder

Overview:
- Immediate-operand decode stage directly upstream of the core's execute path.
- Consumes the instruction byte stream fetched from ROM and decodes one WebAssembly LEB128 immediate per request (u32, s32, u64, s64).
- Delivers a 64-bit value plus the encoded byte length, so the core can advance its fetch address.
- Flags overlong encodings; value-range errors are flagged only when strict checking is compiled in.

Parameters:
- MAX_BYTES, 10, maximum encoded length handled (ceil(64/7)); 32-bit modes are limited to 5.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin decoding; sampled only in IDLE
- is_signed  input  1  decode as signed (sign-extend); sampled with start
- is_64  input  1  1 = 64-bit immediate, 0 = 32-bit; sampled with start
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream data
- in_ready  output  1  byte accepted when in_valid && in_ready
- out_valid  output  1  result/error available
- out_ready  input  1  consumer accepts result
- out_value  output  64  decoded value
- out_len  output  4  bytes consumed (1..10)
- out_error  output  2  00 ok, 01 overlong, 10 overflow

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE.
  - All outputs 0: in_ready, out_valid, out_value, out_len, out_error.
  - Accumulator, byte count and mode flags cleared.
- Asserting reset mid-decode aborts the decode; partial bytes are discarded and no result is emitted.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 latches is_signed/is_64, clears acc and count, goes to ACCUM next cycle.
- ACCUM:
  - in_ready=1.
  - On each handshake: acc |= payload(in_data[6:0]) << 7*count, then count++. Shifted bits at or above 64 are dropped.
  - in_data[7]=0 (final byte): finalise and go to DONE the next cycle.
  - in_data[7]=1 and count+1 == limit (5 for 32-bit, 10 for 64-bit): out_error=01, go to DONE. The offending byte is consumed; out_len=limit.
  - in_valid=0 holds state; no timeout.
- Finalise:
  - Signed: if the final byte's bit6=1 and 7*count < 64, set bits [63:7*count] to 1.
  - 32-bit mode: truncate to [31:0]; bits [63:32] become copies of bit31 when signed, else 0.
- DONE:
  - out_valid=1; out_value, out_len and out_error are stable while out_valid && !out_ready.
  - out_ready=1 returns to IDLE next cycle.
  - start is ignored while in ACCUM or DONE, including in the out_ready cycle; the core must re-issue start.
- Latency: a result is valid the cycle after its final byte handshake. Minimum request-to-result time is 3 cycles (start, byte, valid).
- Throughput: one byte per cycle in ACCUM.
- out_value is 0 whenever out_error != 00.
- in_ready is never asserted outside ACCUM, even if in_valid is held high.

Optional Feature:
- Macro: WASM_LEB128_STRICT_EN.
- Defined: on the final byte at the maximum length, unused payload bits must be zero (unsigned) or equal to the sign bit (signed); otherwise out_error=10. Rules:
  - u32: 5th byte bits[6:4]=0.
  - s32: 5th byte bits[6:3] all equal.
  - u64: 10th byte bits[6:1]=0.
  - s64: 10th byte bits[6:0] = 0x00 or 0x7F.
- Undefined: no range check; excess bits are silently truncated by the width rules, and out_error is never 10.

Decomposition:
- Package wasm_leb_pkg holds:
  - state enum leb_state_t {IDLE, ACCUM, DONE};
  - error enum leb_err_t {LEB_OK=2'b00, LEB_OVERLONG=2'b01, LEB_OVERFLOW=2'b10};
  - constants LEB_MAX32=5 and LEB_MAX64=10.
- One natural sub-module, wasm_leb128_finalize: combinational sign/zero extension, truncation and the strict range check. It takes the accumulator, count, final byte and mode, and returns value and error.

Test Plan:
1. u32, bytes E5 8E 26 -> out_value=0x0000_0000_0009_8765 (624485), out_len=3, out_error=00; out_valid rises 1 cycle after the 0x26 handshake.
2. s64, bytes C0 BB 78 -> out_value=0xFFFF_FFFF_FFFE_1DC0 (-123456), out_len=3. Same bytes as s32 give the same 64-bit value.
3. u32, bytes 80 80 80 80 80 -> out_error=01, out_len=5, out_value=0; in_ready drops after the 5th byte, so a 6th byte is not consumed.
4. u32, bytes FF FF FF FF 7F:
   - with WASM_LEB128_STRICT_EN -> out_error=10;
   - without -> out_value=0x0000_0000_FFFF_FFFF, out_error=00.
   - Bytes FF FF FF FF 0F -> 0xFFFF_FFFF, out_error=00 in both builds.
5. Backpressure: decode 0x2A as u64 with out_ready=0 for 4 cycles -> out_valid, out_value=42 and out_len=1 held stable. Pulsing start during the hold is ignored. out_ready=1 -> IDLE next cycle.
6. Reset mid-decode: start u64, feed 80 80, pull reset low for 1 cycle -> all outputs 0 immediately. A fresh start with byte 07 returns 7, out_len=1.
